// File: rtl/joy_pkg.sv
// Shared constants for the Mega Drive pad serial encoder: button bit indices,
// shift-chain positions and the pin bundle one pad presents to the chain.
package joy_pkg;

    localparam int CHAIN_LEN = 24;

    localparam int BTN_U = 0;
    localparam int BTN_D = 1;
    localparam int BTN_L = 2;
    localparam int BTN_R = 3;
    localparam int BTN_B = 4;
    localparam int BTN_C = 5;
    localparam int BTN_A = 6;
    localparam int BTN_S = 7;
    localparam int BTN_Z = 8;
    localparam int BTN_Y = 9;
    localparam int BTN_X = 10;
    localparam int BTN_M = 11;

    localparam int POS_P9_1 = 4;
    localparam int POS_P6_1 = 5;
    localparam int POS_R1   = 6;
    localparam int POS_L1   = 7;
    localparam int POS_D1   = 8;
    localparam int POS_U1   = 9;
    localparam int POS_P6_2 = 12;
    localparam int POS_P9_2 = 13;
    localparam int POS_R2   = 14;
    localparam int POS_L2   = 15;
    localparam int POS_D2   = 16;
    localparam int POS_U2   = 17;

    typedef struct packed {
        logic u;
        logic d;
        logic l;
        logic r;
        logic p6;
        logic p9;
    } pad_pins_t;

    localparam pad_pins_t PINS_IDLE = pad_pins_t'(6'h3F);

endpackage

// File: rtl/md_pad_emu.sv
// One Mega Drive pad: select-driven phase counter with idle timeout and the
// registered pin multiplexer that maps buttons onto the six DB9 data pins.
module md_pad_emu
    import joy_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 75000,
    parameter int TO_W           = 17
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        sel_i,
    input  logic        sel_edge_i,
    input  logic [11:0] btn_i,
    input  logic        six_btn_i,
    output logic [2:0]  ph_o,
    output pad_pins_t   pins_o
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT_CYCLES);

    logic [2:0]      ph_q, ph_d;
    logic [TO_W-1:0] to_q, to_d;
    pad_pins_t       pins_q, pins_d;

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
    always_comb begin
        ph_d = ph_q;
        to_d = to_q;
        if (sel_edge_i) begin
            ph_d = ph_q + 3'd1;
            to_d = '0;
        end else if (to_q != TO_MAX) begin
            to_d = to_q + TO_W'(1);
            if (to_q == TO_LAST) ph_d = {2'b00, ~sel_i};
        end
    end

    // The six-button extras only appear in phases 5-7; otherwise the pad acts like a three-button one.
    always_comb begin
        if (!ph_q[0]) begin
            pins_d = '{u: btn_i[BTN_U], d: btn_i[BTN_D], l: btn_i[BTN_L], r: btn_i[BTN_R],
                       p6: btn_i[BTN_B], p9: btn_i[BTN_C]};
        end else begin
            pins_d = '{u: btn_i[BTN_U], d: btn_i[BTN_D], l: 1'b0, r: 1'b0,
                       p6: btn_i[BTN_S], p9: btn_i[BTN_A]};
        end
        if (six_btn_i) begin
            case (ph_q)
                3'd5: pins_d = '{u: 1'b0, d: 1'b0, l: 1'b0, r: 1'b0,
                                 p6: btn_i[BTN_S], p9: btn_i[BTN_A]};
                3'd6: pins_d = '{u: btn_i[BTN_Z], d: btn_i[BTN_Y], l: btn_i[BTN_X], r: btn_i[BTN_M],
                                 p6: btn_i[BTN_B], p9: btn_i[BTN_C]};
                3'd7: pins_d = '{u: 1'b1, d: 1'b1, l: 1'b1, r: 1'b1,
                                 p6: btn_i[BTN_S], p9: btn_i[BTN_A]};
                default: ;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ph_q   <= '0;
            to_q   <= '0;
            pins_q <= PINS_IDLE;
        end else begin
            ph_q   <= ph_d;
            to_q   <= to_d;
            pins_q <= pins_d;
        end
    end

    assign ph_o   = ph_q;
    assign pins_o = pins_q;

endmodule

// File: rtl/joy_encoder_md.sv
// Device-side joystick serial interface: synchronises the host lines, runs two
// pad emulators and serialises their pins through a 24-stage load/shift chain.
module joy_encoder_md
    import joy_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 75000,
    parameter int TO_W           = 17
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        joy_clk,
    input  logic        joy_load_n,
    input  logic        joy_select,
    input  logic [11:0] joy1_i,
    input  logic [11:0] joy2_i,
    input  logic [1:0]  six_btn,
    output logic        joy_data,
    output logic [2:0]  phase1_o,
    output logic [2:0]  phase2_o
);

    logic [SYNC_STAGES-1:0] clk_sync_q, load_sync_q, sel_sync_q;
    logic                   clk_prev_q, sel_prev_q;
    logic                   clk_s, load_s, sel_s, clk_rise, sel_edge;
    pad_pins_t              pins1, pins2;
    logic [CHAIN_LEN-1:0]   load_vec, chain_q, chain_d;

    // NOTE: synchroniser and edge-history flops are deliberately left out of reset so they keep tracking the pins and no false edge appears on release.
    always_ff @(posedge clk) begin
        clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], joy_clk};
        load_sync_q <= {load_sync_q[SYNC_STAGES-2:0], joy_load_n};
        sel_sync_q  <= {sel_sync_q[SYNC_STAGES-2:0], joy_select};
        clk_prev_q  <= clk_s;
        sel_prev_q  <= sel_s;
    end

    assign clk_s    = clk_sync_q[SYNC_STAGES-1];
    assign load_s   = load_sync_q[SYNC_STAGES-1];
    assign sel_s    = sel_sync_q[SYNC_STAGES-1];
    assign clk_rise = clk_s & ~clk_prev_q;
    assign sel_edge = sel_s ^ sel_prev_q;

    md_pad_emu #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .TO_W(TO_W)) u_pad1 (
        .clk       (clk),
        .reset_n   (reset_n),
        .sel_i     (sel_s),
        .sel_edge_i(sel_edge),
        .btn_i     (joy1_i),
        .six_btn_i (six_btn[0]),
        .ph_o      (phase1_o),
        .pins_o    (pins1)
    );

    md_pad_emu #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .TO_W(TO_W)) u_pad2 (
        .clk       (clk),
        .reset_n   (reset_n),
        .sel_i     (sel_s),
        .sel_edge_i(sel_edge),
        .btn_i     (joy2_i),
        .six_btn_i (six_btn[1]),
        .ph_o      (phase2_o),
        .pins_o    (pins2)
    );

    always_comb begin
        load_vec           = '1;
        load_vec[POS_P9_1] = pins1.p9;
        load_vec[POS_P6_1] = pins1.p6;
        load_vec[POS_R1]   = pins1.r;
        load_vec[POS_L1]   = pins1.l;
        load_vec[POS_D1]   = pins1.d;
        load_vec[POS_U1]   = pins1.u;
        load_vec[POS_P6_2] = pins2.p6;
        load_vec[POS_P9_2] = pins2.p9;
        load_vec[POS_R2]   = pins2.r;
        load_vec[POS_L2]   = pins2.l;
        load_vec[POS_D2]   = pins2.d;
        load_vec[POS_U2]   = pins2.u;
    end

    // Load is transparent and outranks a coincident shift clock.
    always_comb begin
        chain_d = chain_q;
        if (!load_s)       chain_d = load_vec;
        else if (clk_rise) chain_d = {1'b1, chain_q[CHAIN_LEN-1:1]};
    end

    always_ff @(posedge clk) begin
        if (!reset_n) chain_q <= '1;
        else          chain_q <= chain_d;
    end

    assign joy_data = chain_q[0];

endmodule

// File: tb/tb_joy_encoder_md.sv
// Self-checking bench for joy_encoder_md: directed frame reads with literal
// expectations plus a randomized run compared every cycle to a behavioural model.
module tb_joy_encoder_md;

    localparam int S = 2;
    localparam int T = 400;

    logic        clk = 1'b0;
    logic        reset_n, joy_clk, joy_load_n, joy_select;
    logic [11:0] joy1_i, joy2_i;
    logic [1:0]  six_btn;
    logic        joy_data;
    logic [2:0]  phase1_o, phase2_o;

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 1'b0;

    joy_encoder_md #(.SYNC_STAGES(S), .TIMEOUT_CYCLES(T), .TO_W(9)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .joy_clk   (joy_clk),
        .joy_load_n(joy_load_n),
        .joy_select(joy_select),
        .joy1_i    (joy1_i),
        .joy2_i    (joy2_i),
        .six_btn   (six_btn),
        .joy_data  (joy_data),
        .phase1_o  (phase1_o),
        .phase2_o  (phase2_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, want, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Pin word layout {U,D,L,R,p6,p9}, taken straight from the phase table.
    function automatic logic [5:0] pin_word(int ph, logic [11:0] b, logic six);
        logic u = b[0], d = b[1], l = b[2], r = b[3], bb = b[4], c = b[5];
        logic a = b[6], st = b[7], z = b[8], y = b[9], x = b[10], m = b[11];
        if (six && ph == 5) return {4'b0000, st, a};
        if (six && ph == 6) return {z, y, x, m, bb, c};
        if (six && ph == 7) return {4'b1111, st, a};
        if (ph % 2 == 0)    return {u, d, l, r, bb, c};
        return {u, d, 2'b00, st, a};
    endfunction

    function automatic logic [23:0] frame_of(logic [5:0] p1, logic [5:0] p2);
        logic [23:0] f = '1;
        f[4]  = p1[0]; f[5]  = p1[1]; f[6]  = p1[2]; f[7]  = p1[3]; f[8]  = p1[4]; f[9]  = p1[5];
        f[12] = p2[1]; f[13] = p2[0]; f[14] = p2[2]; f[15] = p2[3]; f[16] = p2[4]; f[17] = p2[5];
        return f;
    endfunction

    logic [S+1:0] h_clk = '0, h_ld = '1, h_sel = '0;
    logic [23:0]  m_ch = '1;
    logic [5:0]   m_pins [2] = '{6'h3F, 6'h3F};
    int           m_ph   [2] = '{0, 0};
    int           m_idle [2] = '{0, 0};

    always @(posedge clk) begin
        h_clk = {h_clk[S:0], joy_clk};
        h_ld  = {h_ld[S:0], joy_load_n};
        h_sel = {h_sel[S:0], joy_select};
        if (!reset_n) begin
            m_ch = '1;
            for (int p = 0; p < 2; p++) begin
                m_ph[p] = 0; m_idle[p] = 0; m_pins[p] = 6'h3F;
            end
        end else begin
            if (!h_ld[S])                     m_ch = frame_of(m_pins[0], m_pins[1]);
            else if (h_clk[S] && !h_clk[S+1]) m_ch = {1'b1, m_ch[23:1]};
            for (int p = 0; p < 2; p++) begin
                m_pins[p] = pin_word(m_ph[p], (p == 0) ? joy1_i : joy2_i, six_btn[p]);
                if (h_sel[S] != h_sel[S+1]) begin
                    m_ph[p] = (m_ph[p] + 1) % 8;
                    m_idle[p] = 0;
                end else begin
                    m_idle[p]++;
                    if (m_idle[p] == T) m_ph[p] = h_sel[S] ? 0 : 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("joy_data_vs_model", 32'(joy_data), 32'(m_ch[0]));
            check("phase1_vs_model", 32'(phase1_o), m_ph[0]);
            check("phase2_vs_model", 32'(phase2_o), m_ph[1]);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_reset(input logic sel, input logic [11:0] j1, input logic [11:0] j2, input logic [1:0] six);
        reset_n = 1'b0; joy_clk = 1'b0; joy_load_n = 1'b1;
        joy_select = sel; joy1_i = j1; joy2_i = j2; six_btn = six;
        repeat (4) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic shift1();
        joy_clk = 1'b1; repeat (4) @(negedge clk);
        joy_clk = 1'b0; repeat (4) @(negedge clk);
    endtask

    task automatic sel_toggle();
        joy_select = ~joy_select;
        repeat (6) @(negedge clk);
    endtask

    task automatic do_load();
        joy_load_n = 1'b0; repeat (6) @(negedge clk);
        joy_load_n = 1'b1; repeat (6) @(negedge clk);
    endtask

    task automatic read_shift(output logic [23:0] f);
        f[0] = joy_data;
        for (int k = 1; k < 24; k++) begin
            shift1();
            f[k] = joy_data;
        end
    endtask

    task automatic read_frame(output logic [23:0] f);
        do_load();
        read_shift(f);
    endtask

    logic [23:0] fr;
    int          n;

    initial begin
        // 1: reset with random pad inputs
        reset_n = 1'b0; joy_clk = 1'b0; joy_load_n = 1'b1;
        joy_select = 1'($urandom_range(1));
        joy1_i = 12'($urandom); joy2_i = 12'($urandom); six_btn = 2'($urandom);
        repeat (4) @(negedge clk);
        chk_en = 1'b1;
        check("reset_joy_data", 32'(joy_data), 32'd1);
        reset_n = 1'b1;
        @(negedge clk);
        check("post_reset_ph1", 32'(phase1_o), 32'd0);
        check("post_reset_ph2", 32'(phase2_o), 32'd0);
        read_shift(fr);
        check("post_reset_chain", 32'(fr), 32'hFFFFFF);

        // 2: U1 pressed, select high
        do_reset(1'b1, 12'hFFE, 12'hFFF, 2'b00);
        read_frame(fr);
        check("frame_u1", 32'(fr), 32'hFFFDFF);
        check("frame_u1_ph", 32'(phase1_o), 32'd0);

        // 3: six-button pads, phases 5 and 6
        do_reset(1'b1, 12'hEFF, 12'hFFF, 2'b11);
        repeat (5) sel_toggle();
        check("six_ph5", 32'(phase1_o), 32'd5);
        read_frame(fr);
        check("six_frame_ph5", 32'(fr), 32'hFC3C3F);
        sel_toggle();
        check("six_ph6", 32'(phase1_o), 32'd6);
        read_frame(fr);
        check("six_frame_ph6_z", 32'(fr), 32'hFFFDFF);

        // 4: three-button pads ignore the extended phases
        do_reset(1'b1, 12'h0FE, 12'hFFF, 2'b00);
        repeat (5) sel_toggle();
        read_frame(fr);
        check("three_frame_ph5", 32'(fr), 32'hFF3D3F);
        sel_toggle();
        check("three_ph6", 32'(phase2_o), 32'd6);
        read_frame(fr);
        check("three_frame_ph6", 32'(fr), 32'hFFFDFF);

        // 5: timeout from ph 3 with select low
        do_reset(1'b1, 12'hFFF, 12'hFFF, 2'b00);
        repeat (2) sel_toggle();
        joy_select = 1'b0;
        n = 0;
        while (phase1_o != 3'd3 && n < 20) begin @(negedge clk); n++; end
        check("reach_ph3", 32'(phase1_o), 32'd3);
        n = 0;
        while (phase1_o == 3'd3 && n < 2 * T) begin @(negedge clk); n++; end
        check("timeout_cycles", n, T);
        check("timeout_ph", 32'(phase1_o), 32'd1);

        // 6: reload mid-frame, then reset mid-frame
        do_reset(1'b1, 12'hFFE, 12'hFFF, 2'b00);
        repeat (2) sel_toggle();
        do_load();
        repeat (9) shift1();
        check("shift9_u1", 32'(joy_data), 32'd0);
        shift1();
        check("shift10_one", 32'(joy_data), 32'd1);
        do_load();
        check("reload_pos0", 32'(joy_data), 32'd1);
        repeat (9) shift1();
        check("reload_shift9_u1", 32'(joy_data), 32'd0);
        reset_n = 1'b0;
        @(negedge clk);
        check("midframe_reset_data", 32'(joy_data), 32'd1);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("midframe_reset_ph", 32'(phase1_o), 32'd0);
        check("midframe_reset_data2", 32'(joy_data), 32'd1);

        // randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(3) == 0)    joy_clk = ~joy_clk;
            if ($urandom_range(15) == 0)   joy_load_n = ~joy_load_n;
            if ($urandom_range(23) == 0)   joy_select = ~joy_select;
            if ($urandom_range(63) == 0)   joy1_i = 12'($urandom);
            if ($urandom_range(63) == 0)   joy2_i = 12'($urandom);
            if ($urandom_range(199) == 0)  six_btn = 2'($urandom);
            reset_n = ($urandom_range(599) != 0);
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/joy_encoder_md.md
Name: joy_encoder_md

Overview:
- Device-side model of the joystick serial interface: emulates the on-board 24-stage parallel-in/serial-out shifter and two Mega Drive pads (3- or 6-button) behind it.
- Driven by the host-side joy_clk / joy_load_n / joy_select lines; produces joy_data from two parallel 12-bit button words.
- Used as the simulation pad model for the decoder, and as the bridge when pads come from USB/BT instead of DB9.

Parameters:
- SYNC_STAGES, 2, synchroniser depth on joy_clk, joy_load_n, joy_select (min 2).
- TIMEOUT_CYCLES, 75000, clk cycles with no select edge before a pad's phase resets (1.5 ms at 50 MHz).
- TO_W, 17, width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, at least 8x the joy_clk frequency.
- reset_n  in  1  synchronous, active-low reset.
- joy_clk  in  1  shift clock from host, asynchronous to clk.
- joy_load_n  in  1  parallel load, active low, asynchronous.
- joy_select  in  1  pad select line, asynchronous.
- joy1_i  in  12  pad 1 buttons MXYZ SACB RLDU, active low. Bit order: [0]U [1]D [2]L [3]R [4]B [5]C [6]A [7]S [8]Z [9]Y [10]X [11]M.
- joy2_i  in  12  pad 2, same format.
- six_btn  in  2  per pad: 1 = 6-button pad, 0 = 3-button pad.
- joy_data  out  1  serial output (chain position 0).
- phase1_o, phase2_o  out  3  current pad phase, for debug and verification.

Behaviour:
- Inputs joy_clk, joy_load_n and joy_select pass through SYNC_STAGES FFs. Edges are detected on the synchronised values.
- Pad phase counter (per pad):
  - ph increments modulo 8 on every edge of the synchronised select.
  - Even phases correspond to select high, odd phases to select low.
  - Timeout counter clears on each select edge. At TIMEOUT_CYCLES it sets ph <= {2'b00, ~sel_s}.
- Pad pin values {U,D,L,R,p6,p9}, registered, updated 1 clk after a phase change:
  - ph 0/2/4 (6-btn) or any even ph (3-btn): U D L R B C.
  - ph 1/3 (6-btn) or any odd ph (3-btn): U D 0 0 S A.
  - ph 5: 0 0 0 0 S A.
  - ph 6: Z Y X M B C, mapped U=Z, D=Y, L=X, R=M.
  - ph 7: 1 1 1 1 S A.
- Chain contents (position: source):
  - 0-3: 1
  - 4: p9_1, 5: p6_1, 6: R1, 7: L1, 8: D1, 9: U1
  - 10-11: 1
  - 12: p6_2, 13: p9_2, 14: R2, 15: L2, 16: D2, 17: U2
  - 18-23: 1
- Load: while the synchronised load_n is low, the chain reloads every clk (transparent load) and shifting is inhibited. joy_data = position 0.
- Shift: on a synchronised joy_clk rising edge with load_n high, the chain shifts toward position 0 and a 1 is shifted into position 23. joy_data changes SYNC_STAGES+1 clk after the joy_clk rising edge.
- Boundary conditions:
  - More than 23 shifts: joy_data stays 1.
  - Load edge coincident with a clock edge: load wins.
  - Select edge coincident with load: the chain captures the previous pin values that clk and the new values on the next clk (load is still low).
- Reset, including mid-frame: chain all 1s, joy_data = 1, ph = 0, timeout counter = 0, pin registers all 1s. Reset has priority over all events.

Decomposition:
- Package joy_pkg holds:
  - button bit index constants BTN_U..BTN_M;
  - chain position constants POS_P9_1..POS_U2;
  - CHAIN_LEN = 24.
- Sub-module md_pad_emu (phase counter, timeout, pin mux) is instantiated twice. The top level holds the synchronisers and the shift chain.

Test Plan:
1. reset_n = 0 for 4 clk with random inputs -> joy_data = 1, phase1_o = phase2_o = 0, all chain bits 1 after release.
2. Select high, joy1_i = 12'hFFE, joy2_i = 12'hFFF, load pulse then 24 joy_clk -> serial stream all 1 except position 9 = 0.
3. six_btn = 2'b11, joy1_i = 12'hEFF (Z pressed), 6 select edges then load -> ph = 6, position 9 = 0. At ph 5 positions 6-9 = 0 and positions 4/5 = A/S.
4. six_btn = 2'b00, ph driven to 5 and 6 -> ph 5 shows positions 6/7 = 0 with U/D from buttons; ph 6 shows UDLRBC (no ZYXM).
5. Select held steady TIMEOUT_CYCLES after reaching ph 3 with select low -> ph = 1 exactly at cycle TIMEOUT_CYCLES.
6. Load asserted after 10 shifts, then reset_n pulsed low mid-frame -> chain reloads position 0 on load; after reset joy_data = 1, ph = 0.
